// File: rtl/sram_block_controller.sv
// Cache-block controller for a 16-bit asynchronous SRAM: four-halfword block reads, two-halfword word writes.
// Optional build macro SRAM_ACCESS_COUNT_EN adds a 32-bit completed-access counter port.
module sram_block_controller #(
  parameter int ADDRESS_LEN      = 32,
  parameter int SRAM_ADDR_LEN    = 18,
  parameter int BASE_ADDR        = 1024,
  parameter int SRAM_WAIT_CYCLES = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ADDRESS_LEN-1:0]   sram_address,
  input  logic [31:0]              sram_write_data,
  input  logic                     sram_write_en,
  input  logic                     sram_read_en,
  output logic [63:0]              sram_read_data,
  output logic                     sram_ready,
`ifdef SRAM_ACCESS_COUNT_EN
  output logic [31:0]              sram_access_count,
`endif
  inout  wire  [15:0]              SRAM_DQ,
  output logic [SRAM_ADDR_LEN-1:0] SRAM_ADDR,
  output logic                     SRAM_WE_N,
  output logic                     SRAM_OE_N,
  output logic                     SRAM_CE_N,
  output logic                     SRAM_UB_N,
  output logic                     SRAM_LB_N
);

  localparam int PHYS_LEN = SRAM_ADDR_LEN + 1;
  localparam int CNT_W    = (SRAM_WAIT_CYCLES > 2) ? $clog2(SRAM_WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST_CYC     = CNT_W'(SRAM_WAIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] PRE_LAST_CYC = CNT_W'(SRAM_WAIT_CYCLES - 2);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t                   state;
  logic [1:0]               slot;
  logic [CNT_W-1:0]         wait_cnt;
  logic [47:0]              shadow;
  logic [15:0]              wr_hi;
  logic [15:0]              dq_out;
  logic                     dq_oe;

  logic [ADDRESS_LEN-1:0]   offset;
  logic [PHYS_LEN-1:0]      phys;
  logic [SRAM_ADDR_LEN-1:0] read_base;
  logic [SRAM_ADDR_LEN-1:0] write_base;

  // Out-of-range addresses simply wrap into the SRAM; there is no range check.
  assign offset     = sram_address - ADDRESS_LEN'(BASE_ADDR);
  assign phys       = offset[PHYS_LEN-1:0];
  assign read_base  = {phys[PHYS_LEN-1:3], 2'b00};
  assign write_base = {phys[PHYS_LEN-1:2], 1'b0};

  assign SRAM_DQ   = dq_oe ? dq_out : 16'hzzzz;
  assign SRAM_CE_N = 1'b0;
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;

  // NOTE: all state and registered outputs use non-blocking assignments so every
  // branch sees the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      slot           <= 2'd0;
      wait_cnt       <= '0;
      shadow         <= '0;
      wr_hi          <= '0;
      dq_out         <= '0;
      dq_oe          <= 1'b0;
      SRAM_ADDR      <= '0;
      SRAM_WE_N      <= 1'b1;
      SRAM_OE_N      <= 1'b1;
      sram_ready     <= 1'b0;
      sram_read_data <= '0;
    end else begin
      sram_ready <= 1'b0;
      case (state)
        IDLE: begin
          slot     <= 2'd0;
          wait_cnt <= '0;
          if (sram_read_en) begin
            state     <= READ;
            SRAM_ADDR <= read_base;
            SRAM_OE_N <= 1'b0;
          end else if (sram_write_en) begin
            state     <= WRITE;
            SRAM_ADDR <= write_base;
            dq_out    <= sram_write_data[15:0];
            wr_hi     <= sram_write_data[31:16];
            dq_oe     <= 1'b1;
            SRAM_WE_N <= 1'b0;
          end
        end

        READ: begin
          if (wait_cnt == LAST_CYC) begin
            wait_cnt <= '0;
            if (slot == 2'd3) begin
              // Last halfword bypasses the shadow so data is valid alongside ready.
              state          <= DONE;
              SRAM_OE_N      <= 1'b1;
              sram_read_data <= {SRAM_DQ, shadow};
              sram_ready     <= 1'b1;
            end else begin
              case (slot)
                2'd0:    shadow[15:0]  <= SRAM_DQ;
                2'd1:    shadow[31:16] <= SRAM_DQ;
                default: shadow[47:32] <= SRAM_DQ;
              endcase
              slot      <= slot + 2'd1;
              SRAM_ADDR <= SRAM_ADDR + SRAM_ADDR_LEN'(1);
            end
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end

        WRITE: begin
          if (wait_cnt == LAST_CYC) begin
            wait_cnt <= '0;
            if (slot == 2'd0) begin
              slot      <= 2'd1;
              SRAM_ADDR <= SRAM_ADDR + SRAM_ADDR_LEN'(1);
              dq_out    <= wr_hi;
              SRAM_WE_N <= 1'b0;
            end else begin
              state      <= DONE;
              dq_oe      <= 1'b0;
              sram_ready <= 1'b1;
            end
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
            // WE_N rises for the final cycle of the slot, giving each halfword its own write edge.
            if (wait_cnt == PRE_LAST_CYC) SRAM_WE_N <= 1'b1;
          end
        end

        DONE: state <= IDLE;

        default: state <= IDLE;
      endcase
    end
  end

`ifdef SRAM_ACCESS_COUNT_EN
  logic [31:0] access_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                access_cnt <= '0;
    else if (state == DONE) access_cnt <= access_cnt + 32'd1;
  end

  assign sram_access_count = access_cnt;
`endif

endmodule

// File: doc/sram_block_controller.md
Name: sram_block_controller

Overview:
Memory-side stage directly downstream of the cache controller. It consumes that block's SRAM request (address, 32-bit write data, read/write enables) and drives the board's 16-bit asynchronous SRAM. Reads return a full 64-bit cache block assembled from four halfword accesses; writes store one 32-bit word as two halfword accesses. A one-cycle ready pulse signals completion.

Parameters:
ADDRESS_LEN, 32, width of the processor byte address
SRAM_ADDR_LEN, 18, halfword address width of the external SRAM
BASE_ADDR, 1024, processor byte address that maps to SRAM byte 0
SRAM_WAIT_CYCLES, 5, clock cycles per halfword access (minimum 2)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-high reset
sram_address  in  ADDRESS_LEN  processor byte address of the request
sram_write_data  in  32  word to write
sram_write_en  in  1  write request; a single-cycle pulse is sufficient
sram_read_en  in  1  read request; held by the requester until ready
sram_read_data  out  64  assembled block; halfword 0 in bits [15:0]
sram_ready  out  1  one-cycle completion pulse
SRAM_DQ  inout  16  SRAM data bus
SRAM_ADDR  out  SRAM_ADDR_LEN  SRAM halfword address
SRAM_WE_N, SRAM_OE_N, SRAM_CE_N, SRAM_UB_N, SRAM_LB_N  out  1 each  active-low SRAM strobes

Behaviour:
- Clock and reset: clk is the only clock; rst is asynchronous and active-high.
- Reset values: state IDLE, sram_ready 0, sram_read_data 0, SRAM_WE_N 1, SRAM_OE_N 1, SRAM_DQ high-Z, SRAM_ADDR 0, counters 0. SRAM_CE_N, SRAM_UB_N and SRAM_LB_N are held at 0 permanently.
- Address mapping: phys = sram_address - BASE_ADDR, truncated to 19 bits with no range check.
  - Write halfword base = {phys[18:2], 0}.
  - Read block base = {phys[18:3], 00}.
- States: IDLE, READ, WRITE, DONE.
- IDLE:
  - Requests are sampled only in IDLE. If sram_read_en=1 the block latches the address and enters READ; read has priority when both enables are high.
  - Otherwise, if sram_write_en=1, it latches the address and data and enters WRITE.
  - Enables seen in any other state are ignored; nothing is queued.
- READ:
  - 4 slots of SRAM_WAIT_CYCLES cycles each, with slot index k = 0..3.
  - SRAM_ADDR = block base + k, SRAM_OE_N = 0, DQ high-Z.
  - SRAM_DQ is sampled on the last cycle of each slot into a shadow register at bits [16k+15:16k].
  - After slot 3 the block enters DONE.
- WRITE:
  - 2 slots, with k = 0 (data[15:0]) and k = 1 (data[31:16]).
  - SRAM_ADDR = halfword base + k and DQ is driven for the whole slot.
  - SRAM_WE_N = 0 except on the last cycle of each slot, where it is 1 so every halfword gets its own write edge.
  - After slot 1 the block enters DONE.
- DONE:
  - sram_ready = 1 for exactly one cycle, then IDLE.
  - After a read, sram_read_data is loaded from the shadow register on entry to DONE, so it is valid in the same cycle as sram_ready.
  - sram_read_data holds its value until the next read completes; writes do not change it.
- Latency (W = SRAM_WAIT_CYCLES): with the request sampled at edge T, sram_ready is high during cycle T+4W+1 for a read and T+2W+1 for a write. With W=5 this is 21 for a read and 11 for a write.
- A new request is accepted in the cycle after DONE; back-to-back throughput is one request per 4W+2 (read) or 2W+2 (write) cycles.
- Reset mid-operation: the block aborts immediately to reset values. A write interrupted by reset may be partial, and no ready pulse is issued.
- sram_ready is never high in IDLE, READ or WRITE.

Optional Feature:
SRAM_ACCESS_COUNT_EN
- Defined: adds output port sram_access_count (32 bits). It increments by 1 in every DONE cycle, wraps at 2^32-1 to 0, and resets to 0.
- Undefined: the port and the counter are absent, and behaviour is otherwise identical.

Test Plan:
- Reset: assert rst mid-READ (slot 2) -> same cycle: DQ high-Z, WE_N=OE_N=1, sram_ready=0, sram_read_data=0; after release, IDLE accepts a new request.
- Write: address 1036, data 0xDEADBEEF as a 1-cycle pulse at T -> SRAM model halfword 6=0xBEEF, 7=0xDEAD; two distinct WE_N low pulses; sram_ready high only at T+11.
- Read: model preloaded with halfwords 4=0x5678 and 5=0x1234 (6 and 7 from the write test); read_en held at address 1032 -> sram_ready at T+21 with sram_read_data=0xDEADBEEF12345678, held after read_en drops.
- Alignment: read at address 1044 -> SRAM_ADDR sequence 8, 9, 10, 11 (block base from phys 20).
- Both enables high in IDLE at address 1024 -> a read is performed (OE_N low, WE_N never low, SRAM_ADDR 0..3); a write_en pulse issued during READ is ignored and the model is unchanged.
- With SRAM_ACCESS_COUNT_EN: one write then two reads -> sram_access_count=3; with the counter forced to 0xFFFFFFFF, one more access -> 0.
